batch_line_buffer: RTL and testbench

- Downstream neighbour of the HDMI input stage.
- Captures the distributed per-channel pixel batches (one word = 8*BATCH_SIZE bits per channel) for one image row into a ping-pong pair of line banks.
- Streams each completed row, word by word, to the matrix output logic over a valid/ready handshake.
- Decouples the bursty HDMI row write from the slower matrix consumer and drops whole rows cleanly when the consumer falls behind.

---
 rtl/batch_line_buffer_pkg.sv | 12 +
 rtl/line_bank_ram.sv | 22 ++
 rtl/batch_line_buffer.sv | 141 ++++++++++++++
 tb/tb_batch_line_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/batch_line_buffer_pkg.sv
// Shared types for the batch line buffer: read FSM states, bank index, address-width helper.
package batch_line_buffer_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} rd_state_t;

  typedef logic bank_idx_t;

  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_bank_ram.sv
// One channel of the ping-pong line store: write port plus registered read port, addressed {bank, addr}.
module line_bank_ram #(
  parameter int W  = 128,
  parameter int AW = 9
)(
  input  logic          I_clk,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW:0]   rd_addr,
  output logic [W-1:0]  rd_data
);

  // Bank bit on top keeps both banks power-of-two aligned; the tail of each bank is never written.
  logic [W-1:0] mem [0:(1<<(AW+1))-1];

  always_ff @(posedge I_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/batch_line_buffer.sv
// Ping-pong row buffer between the HDMI batch writer and the matrix consumer.
// Optional statistics outputs are enabled with BATCH_LINE_BUFFER_STATS_EN.
module batch_line_buffer
  import batch_line_buffer_pkg::*;
#(
  parameter int CHANNEL_COUNT = 3,
  parameter int BATCH_SIZE    = 16,
  parameter int BLOCK_DEPTH   = 480,
  localparam int AW           = aw_of(BLOCK_DEPTH)
)(
  input  logic                                       I_clk,
  input  logic                                       I_rst,
  input  logic                                       I_wr_en,
  input  logic [AW-1:0]                              I_wr_addr,
  input  logic [CHANNEL_COUNT-1:0][8*BATCH_SIZE-1:0] I_wr_data,
  input  logic                                       I_row_end,
  output logic                                       O_rd_valid,
  input  logic                                       I_rd_ready,
  output logic [CHANNEL_COUNT-1:0][8*BATCH_SIZE-1:0] O_rd_data,
  output logic [AW-1:0]                              O_rd_addr,
  output logic                                       O_rd_last,
  output logic [AW:0]                                O_row_len,
  output logic [1:0]                                 O_bank_full,
  output logic                                       O_row_dropped
`ifdef BATCH_LINE_BUFFER_STATS_EN
  ,
  output logic [15:0]                                O_drop_count,
  output logic [AW:0]                                O_max_row_len
`endif
);

  localparam int          W       = 8*BATCH_SIZE;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(BLOCK_DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  rd_state_t           state;
  bank_idx_t           wr_bank, rd_bank;
  logic [AW:0]         wr_len;
  logic [1:0][AW:0]    row_len_q;
  logic [AW-1:0]       rd_ptr;

  logic                wr_hit, hs, release_rd, commit, drop;
  logic [AW:0]         wr_end, len_next, cur_len;
  logic [1:0]          full_eff, full_next;
  logic [AW-1:0]       rd_ptr_next;
  logic [AW:0]         ram_raddr;
  logic [CHANNEL_COUNT-1:0][W-1:0] ram_q;

  always_comb begin
    wr_hit     = I_wr_en && ({1'b0, I_wr_addr} < DEPTH_L);
    wr_end     = {1'b0, I_wr_addr} + LEN_ONE;
    len_next   = (wr_hit && (wr_end > wr_len)) ? wr_end : wr_len;
    cur_len    = row_len_q[rd_bank];
    hs         = (state == STREAM) && O_rd_valid && I_rd_ready;
    release_rd = hs && O_rd_last;
    // A bank drained this cycle is free for the row closing this cycle.
    full_eff   = O_bank_full;
    if (release_rd) full_eff[rd_bank] = 1'b0;
    commit     = I_row_end && (len_next != '0) && !full_eff[~wr_bank];
    drop       = I_row_end && (len_next != '0) &&  full_eff[~wr_bank];
    full_next  = full_eff;
    if (commit) full_next[wr_bank] = 1'b1;
    rd_ptr_next = (hs && !O_rd_last) ? rd_ptr + PTR_ONE : rd_ptr;
    ram_raddr   = {rd_bank, rd_ptr_next};
  end

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
    line_bank_ram #(.W(W), .AW(AW)) u_ram (
      .I_clk   (I_clk),
      .wr_en   (wr_hit),
      .wr_addr ({wr_bank, I_wr_addr}),
      .wr_data (I_wr_data[c]),
      .rd_addr (ram_raddr),
      .rd_data (ram_q[c])
    );
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state         <= IDLE;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_len        <= '0;
      row_len_q     <= '0;
      rd_ptr        <= '0;
      O_bank_full   <= 2'b00;
      O_row_dropped <= 1'b0;
      O_rd_valid    <= 1'b0;
      O_rd_data     <= '0;
      O_rd_addr     <= '0;
      O_rd_last     <= 1'b0;
      O_row_len     <= '0;
    end else begin
      O_row_dropped <= drop;
      O_bank_full   <= full_next;
      wr_len        <= I_row_end ? '0 : len_next;
      if (commit) begin
        row_len_q[wr_bank] <= len_next;
        wr_bank            <= ~wr_bank;
      end

      case (state)
        IDLE: if (O_bank_full[rd_bank]) state <= LOAD;
        LOAD: begin
          O_rd_data  <= ram_q;
          O_rd_valid <= 1'b1;
          O_rd_addr  <= rd_ptr;
          O_rd_last  <= ({1'b0, rd_ptr} == cur_len - LEN_ONE);
          O_row_len  <= cur_len;
          state      <= STREAM;
        end
        STREAM: if (hs) begin
          O_rd_valid <= 1'b0;
          if (O_rd_last) begin
            rd_bank <= ~rd_bank;
            rd_ptr  <= '0;
            state   <= IDLE;
          end else begin
            rd_ptr  <= rd_ptr_next;
            state   <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BATCH_LINE_BUFFER_STATS_EN
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_drop_count  <= '0;
      O_max_row_len <= '0;
    end else begin
      if (drop && (O_drop_count != 16'hFFFF)) O_drop_count <= O_drop_count + 16'd1;
      if (commit && (len_next > O_max_row_len)) O_max_row_len <= len_next;
    end
  end
`endif

endmodule

// File: tb/tb_batch_line_buffer.sv
// Randomized and directed bench for batch_line_buffer against a row-level scoreboard model.
module tb_batch_line_buffer;

  localparam int CC = 3, BS = 16, BD = 480, AW = 9;
  localparam int W = 8*BS, DW = CC*W;

  logic                 I_clk = 1'b0;
  logic                 I_rst = 1'b1, I_wr_en = 1'b0, I_row_end = 1'b0, I_rd_ready = 1'b0;
  logic [AW-1:0]        I_wr_addr = '0;
  logic [CC-1:0][W-1:0] I_wr_data = '0;
  logic                 O_rd_valid, O_rd_last, O_row_dropped;
  logic [CC-1:0][W-1:0] O_rd_data;
  logic [AW-1:0]        O_rd_addr;
  logic [AW:0]          O_row_len;
  logic [1:0]           O_bank_full;
`ifdef BATCH_LINE_BUFFER_STATS_EN
  logic [15:0]          O_drop_count;
  logic [AW:0]          O_max_row_len;
`endif

  batch_line_buffer #(.CHANNEL_COUNT(CC), .BATCH_SIZE(BS), .BLOCK_DEPTH(BD)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_wr_en(I_wr_en), .I_wr_addr(I_wr_addr),
    .I_wr_data(I_wr_data), .I_row_end(I_row_end), .O_rd_valid(O_rd_valid),
    .I_rd_ready(I_rd_ready), .O_rd_data(O_rd_data), .O_rd_addr(O_rd_addr),
    .O_rd_last(O_rd_last), .O_row_len(O_row_len), .O_bank_full(O_bank_full),
    .O_row_dropped(O_row_dropped)
`ifdef BATCH_LINE_BUFFER_STATS_EN
    , .O_drop_count(O_drop_count), .O_max_row_len(O_max_row_len)
`endif
  );

  always #5 I_clk = ~I_clk;

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: at most one completed row may wait for the consumer while the next one is written.
  typedef struct { logic [DW-1:0] data; int addr; bit last; int len; } word_t;
  word_t          exp_q[$];
  int             pending, cur_len, drop_total, max_len, obs_drops;
  logic [DW-1:0]  cur_row [BD];
  bit             exp_drop, hold_prev;
  logic [DW-1:0]  prev_data;
  logic [AW-1:0]  prev_addr;
  logic           prev_last;
  logic [AW:0]    prev_len;

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_step(input bit we, input int addr, input logic [DW-1:0] d,
                            input bit re, input bit rdy);
    word_t w;
    exp_drop = 1'b0;
    if (O_rd_valid && rdy) begin
      if (exp_q.size() == 0) chk("rd_valid_spurious", DW'(O_rd_valid), DW'(0));
      else begin
        w = exp_q.pop_front();
        chk("rd_data",  O_rd_data, w.data);
        chk("rd_addr",  DW'(O_rd_addr), DW'(w.addr));
        chk("rd_last",  DW'(O_rd_last), DW'(w.last));
        chk("row_len",  DW'(O_row_len), DW'(w.len));
        if (w.last) pending--;
      end
    end
    if (we && addr < BD) begin
      cur_row[addr] = d;
      if (addr + 1 > cur_len) cur_len = addr + 1;
    end
    if (re && cur_len > 0) begin
      if (pending == 0) begin
        for (int i = 0; i < cur_len; i++) begin
          w.data = cur_row[i]; w.addr = i; w.last = (i == cur_len - 1); w.len = cur_len;
          exp_q.push_back(w);
        end
        pending++;
        if (cur_len > max_len) max_len = cur_len;
      end else begin
        exp_drop = 1'b1;
        if (drop_total < 65535) drop_total++;
      end
      cur_len = 0;
    end
  endtask

  task automatic check_outputs();
    chk("row_dropped", DW'(O_row_dropped), DW'(exp_drop));
    chk("bank_full_cnt", DW'($countones(O_bank_full)), DW'(pending));
    if (O_row_dropped) obs_drops++;
    if (hold_prev) begin
      chk("hold_valid", DW'(O_rd_valid), DW'(1));
      chk("hold_data",  O_rd_data, prev_data);
      chk("hold_addr",  DW'(O_rd_addr), DW'(prev_addr));
      chk("hold_last",  DW'(O_rd_last), DW'(prev_last));
      chk("hold_len",   DW'(O_row_len), DW'(prev_len));
    end
`ifdef BATCH_LINE_BUFFER_STATS_EN
    chk("drop_count",  DW'(O_drop_count), DW'(drop_total));
    chk("max_row_len", DW'(O_max_row_len), DW'(max_len));
`endif
  endtask

  task automatic step(input bit we, input int addr, input logic [DW-1:0] d,
                      input bit re, input bit rdy);
    I_rst = 1'b0; I_wr_en = we; I_wr_addr = AW'(addr); I_wr_data = d;
    I_row_end = re; I_rd_ready = rdy;
    hold_prev = O_rd_valid && !rdy;
    prev_data = O_rd_data; prev_addr = O_rd_addr; prev_last = O_rd_last; prev_len = O_row_len;
    model_step(we, addr, d, re, rdy);
    @(posedge I_clk); @(negedge I_clk);
    check_outputs();
  endtask

  task automatic step_rst();
    I_rst = 1'b1; I_wr_en = 1'b0; I_row_end = 1'b0; I_rd_ready = 1'b0;
    I_wr_addr = '0; I_wr_data = '0;
    exp_q.delete(); pending = 0; cur_len = 0; exp_drop = 1'b0; hold_prev = 1'b0;
    drop_total = 0; max_len = 0;
    @(posedge I_clk); @(negedge I_clk);
    chk("rst_valid",     DW'(O_rd_valid), DW'(0));
    chk("rst_bank_full", DW'(O_bank_full), DW'(0));
    chk("rst_dropped",   DW'(O_row_dropped), DW'(0));
    chk("rst_addr",      DW'(O_rd_addr), DW'(0));
    chk("rst_last",      DW'(O_rd_last), DW'(0));
    chk("rst_row_len",   DW'(O_row_len), DW'(0));
    chk("rst_data",      O_rd_data, '0);
    I_rst = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, '0, 1'b0, rdy);
  endtask

  task automatic write_row(input int len, input bit rdy);
    for (int a = 0; a < len; a++) step(1'b1, a, rnd(), 1'b0, rdy);
    step(1'b0, 0, '0, 1'b1, rdy);
  endtask

  task automatic wait_word(input int addr);
    for (int k = 0; k < 200; k++) begin
      if (O_rd_valid && O_rd_addr == AW'(addr)) break;
      step(1'b0, 0, '0, 1'b0, 1'b1);
    end
    chk("wait_word_addr", DW'(O_rd_addr), DW'(addr));
  endtask

  initial begin
    @(negedge I_clk);
    step_rst(); step_rst();

    // single row with commit-to-valid latency
    write_row(30, 1'b1);
    chk("lat_valid0", DW'(O_rd_valid), DW'(0));
    step(1'b0, 0, '0, 1'b0, 1'b1);
    chk("lat_valid1", DW'(O_rd_valid), DW'(0));
    step(1'b0, 0, '0, 1'b0, 1'b1);
    chk("lat_valid2", DW'(O_rd_valid), DW'(1));
    idle(70, 1'b1);
    chk("single_drained", DW'(O_bank_full), DW'(0));

    // back-pressure mid-row
    write_row(12, 1'b1);
    wait_word(5);
    idle(10, 1'b0);
    idle(40, 1'b1);

    // overflow: first row held, the next two closing rows are discarded
    obs_drops = 0;
    for (int r = 0; r < 3; r++) write_row(20, 1'b0);
    idle(60, 1'b1);
    chk("overflow_drops", DW'(obs_drops), DW'(2));

    // release collision: row end lands on the final-word handshake
    write_row(4, 1'b0);
    for (int a = 0; a < 6; a++) step(1'b1, a, rnd(), 1'b0, 1'b0);
    obs_drops = 0;
    for (int k = 0; k < 100; k++) begin
      if (O_rd_valid && O_rd_last) begin
        step(1'b0, 0, '0, 1'b1, 1'b1);
        break;
      end
      step(1'b0, 0, '0, 1'b0, 1'b1);
    end
    chk("collision_no_drop", DW'(obs_drops), DW'(0));
    chk("collision_full", DW'($countones(O_bank_full)), DW'(1));
    idle(40, 1'b1);

    // boundaries: out-of-range write, empty row ends, same-cycle write + row end
    step(1'b1, BD, rnd(), 1'b0, 1'b1);
    step(1'b0, 0, '0, 1'b1, 1'b1);
    step(1'b1, BD + 7, rnd(), 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("empty_row_full", DW'(O_bank_full), DW'(0));
    for (int a = 0; a < 5; a++) step(1'b1, a, rnd(), 1'b0, 1'b1);
    step(1'b1, BD, rnd(), 1'b1, 1'b1);
    idle(20, 1'b1);
    for (int a = 0; a < 3; a++) step(1'b1, a, rnd(), 1'b0, 1'b1);
    step(1'b1, 3, rnd(), 1'b1, 1'b1);
    idle(20, 1'b1);

    // reset while streaming word 5
    write_row(10, 1'b1);
    wait_word(5);
    step_rst();
    write_row(6, 1'b1);
    idle(30, 1'b1);

    // randomized rows with random consumer readiness
    for (int r = 0; r < 60; r++) begin
      int len;
      bit merge;
      len = $urandom_range(1, 40);
      merge = $urandom_range(0, 1) != 0;
      for (int a = 0; a < len; a++) begin
        if ($urandom_range(0, 9) == 0) step(1'b1, $urandom_range(BD, 511), rnd(), 1'b0, ($urandom % 3) != 0);
        if ($urandom_range(0, 5) == 0) step(1'b0, 0, '0, 1'b0, ($urandom % 3) != 0);
        step(1'b1, a, rnd(), merge && (a == len - 1), ($urandom % 3) != 0);
      end
      if (!merge) step(1'b0, 0, '0, 1'b1, ($urandom % 3) != 0);
      if ($urandom_range(0, 7) == 0) step(1'b0, 0, '0, 1'b1, 1'b1);
      if ($urandom_range(0, 49) == 0) step_rst();
      idle($urandom_range(0, 30), ($urandom % 3) != 0);
    end
    idle(200, 1'b1);
    chk("final_queue_empty", DW'(exp_q.size()), DW'(0));
    chk("final_bank_full", DW'(O_bank_full), DW'(0));
    chk("final_valid", DW'(O_rd_valid), DW'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
